// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encodings,
// default frame parameters, the oversampling ratio and the data
// alignment helper used when a frame completes.
package uart_rx_pkg;

    // Receiver FSM states, 2-bit encoded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } rx_state_e;

    localparam int DBIT_DEFAULT    = 8;   // data bits per frame
    localparam int SB_TICK_DEFAULT = 16;  // ticks per stop bit (16 = 1 stop, 32 = 2 stop)
    localparam int OVERSAMPLE      = 16;  // s_tick pulses per bit period

    // Data bits enter the shift register at bit 7 and move right, so a
    // frame shorter than 8 bits ends up MSB-aligned; shift it down so the
    // first received bit sits at bit 0 and the unused upper bits are 0.
    function automatic logic [7:0] align_lsb(input logic [7:0] sr, input int unsigned dbit);
        return sr >> (32'd8 - dbit);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: the oversampling tick and serial line going in,
// the received byte, completion pulse and framing error coming out.
// The slave modport is the receiver; the master modport is whatever
// drives the line and consumes the bytes.
interface uart_rx_if;

    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    modport master (
        output s_tick,
        output rx,
        input  dout,
        input  rx_done_tick,
        input  frame_err
    );

    modport slave (
        input  s_tick,
        input  rx,
        output dout,
        output rx_done_tick,
        output frame_err
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. Resets to
// RESET_VAL so an idle-high line does not look like a falling edge
// when reset is released.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling. The line is synchronized, a
// falling edge opens a frame, the start bit is re-checked at its middle
// to reject glitches, data bits are sampled mid-bit LSB first, and the
// stop bit is sampled at the end of the stop period to flag framing
// errors. The byte and error flag are registered and held until the
// next frame completes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = SB_TICK_DEFAULT
) (
    input  logic      clock,
    input  logic      reset,
    uart_rx_if.slave  bus
);

    // Tick counter must reach SB_TICK-1 in the stop state
    localparam int S_W = (SB_TICK > OVERSAMPLE) ? 5 : 4;

    localparam logic [S_W-1:0] S_ZERO      = S_W'(0);
    localparam logic [S_W-1:0] S_ONE       = S_W'(1);
    localparam logic [S_W-1:0] S_MID       = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [2:0]     N_ZERO      = 3'd0;
    localparam logic [2:0]     N_ONE       = 3'd1;
    localparam logic [2:0]     N_LAST      = 3'(DBIT - 1);

    logic            rx_sync_s;

    rx_state_e       state_r,  state_nxt_s;
    logic [S_W-1:0]  s_r,      s_nxt_s;
    logic [2:0]      n_r,      n_nxt_s;
    logic [7:0]      b_r,      b_nxt_s;
    logic [7:0]      dout_r,   dout_nxt_s;
    logic            ferr_r,   ferr_nxt_s;
    logic            done_r,   done_nxt_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_sync_s)
    );

    // FSM, counters, shift register and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            s_r     <= S_ZERO;
            n_r     <= N_ZERO;
            b_r     <= 8'h00;
            dout_r  <= 8'h00;
            ferr_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            s_r     <= s_nxt_s;
            n_r     <= n_nxt_s;
            b_r     <= b_nxt_s;
            dout_r  <= dout_nxt_s;
            ferr_r  <= ferr_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Next-state logic: everything holds unless a state rule fires
    always_comb begin
        state_nxt_s = state_r;
        s_nxt_s     = s_r;
        n_nxt_s     = n_r;
        b_nxt_s     = b_r;
        dout_nxt_s  = dout_r;
        ferr_nxt_s  = ferr_r;
        done_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Leaving idle does not wait for a tick
                if (!rx_sync_s) begin
                    state_nxt_s = ST_START;
                    s_nxt_s     = S_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_START: begin
                if (bus.s_tick) begin
                    if (s_r == S_MID) begin
                        // Middle of start bit: still low means a real frame
                        if (!rx_sync_s) begin
                            state_nxt_s = ST_DATA;
                            s_nxt_s     = S_ZERO;
                            n_nxt_s     = N_ZERO;
                        end else begin
                            state_nxt_s = ST_IDLE;
                            s_nxt_s     = S_ZERO;
                        end
                    end else begin
                        s_nxt_s = s_r + S_ONE;
                    end
                end else begin
                    s_nxt_s = s_r;
                end
            end

            ST_DATA: begin
                if (bus.s_tick) begin
                    if (s_r == S_BIT_LAST) begin
                        s_nxt_s = S_ZERO;
                        b_nxt_s = {rx_sync_s, b_r[7:1]};
                        if (n_r == N_LAST) begin
                            state_nxt_s = ST_STOP;
                        end else begin
                            n_nxt_s = n_r + N_ONE;
                        end
                    end else begin
                        s_nxt_s = s_r + S_ONE;
                    end
                end else begin
                    s_nxt_s = s_r;
                end
            end

            ST_STOP: begin
                if (bus.s_tick) begin
                    if (s_r == S_STOP_LAST) begin
                        // Deliver the byte even when the stop bit is bad
                        state_nxt_s = ST_IDLE;
                        s_nxt_s     = S_ZERO;
                        dout_nxt_s  = align_lsb(b_r, DBIT);
                        ferr_nxt_s  = ~rx_sync_s;
                        done_nxt_s  = 1'b1;
                    end else begin
                        s_nxt_s = s_r + S_ONE;
                    end
                end else begin
                    s_nxt_s = s_r;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                s_nxt_s     = S_ZERO;
                n_nxt_s     = N_ZERO;
            end
        endcase
    end

    assign bus.dout         = dout_r;
    assign bus.frame_err    = ferr_r;
    assign bus.rx_done_tick = done_r;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx. Two receivers (8 and 7
// data bits) share one clock and a 16x tick generated every 4 clocks;
// each serial line carries 64 clocks per bit. Expected frames come from
// a byte-level model: every complete frame sent yields (data masked to
// the frame width, frame_err = stop bit was 0); aborted or glitched
// frames yield nothing.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CPB = 64;  // clocks per bit

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Tick every 4 clocks
    logic [1:0] tick_cnt;
    logic       s_tick;
    always @(posedge clock or posedge reset) begin
        if (reset) tick_cnt <= 2'd0;
        else       tick_cnt <= tick_cnt + 2'd1;
    end
    assign s_tick = (tick_cnt == 2'd3);

    uart_rx_if bus8();
    uart_rx_if bus7();
    assign bus8.s_tick = s_tick;
    assign bus7.s_tick = s_tick;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (.clock(clock), .reset(reset), .bus(bus8.slave));
    uart_rx #(.DBIT(7), .SB_TICK(16)) dut7 (.clock(clock), .reset(reset), .bus(bus7.slave));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor: capture each completion pulse and count its width
    logic [8:0] got8[$], got7[$];
    int   hi8 = 0, rise8 = 0, hi7 = 0, rise7 = 0;
    logic prev8 = 1'b0, prev7 = 1'b0;
    always @(negedge clock) begin
        if (bus8.rx_done_tick) begin
            hi8++;
            if (!prev8) begin
                rise8++;
                got8.push_back({bus8.frame_err, bus8.dout});
            end
        end
        if (bus7.rx_done_tick) begin
            hi7++;
            if (!prev7) begin
                rise7++;
                got7.push_back({bus7.frame_err, bus7.dout});
            end
        end
        prev8 = bus8.rx_done_tick;
        prev7 = bus7.rx_done_tick;
    end

    // Reference model
    logic [8:0] exp8[$], exp7[$];
    logic [8:0] last8 = 9'h000, last7 = 9'h000;

    task automatic model_frame(input int which, input logic [7:0] data, input int nbits, input logic stop_val);
        logic [7:0] mask;
        logic [8:0] e;
        mask = 8'((1 << nbits) - 1);
        e    = {~stop_val, data & mask};
        if (which == 0) begin exp8.push_back(e); last8 = e; end
        else            begin exp7.push_back(e); last7 = e; end
    endtask

    task automatic drive_bit(input int which, input logic v, input int clks);
        if (which == 0) bus8.rx = v;
        else            bus7.rx = v;
        repeat (clks) @(negedge clock);
    endtask

    // A low stop bit is held for 48 clocks only: long enough to cover the
    // stop sample, short enough that the line is high again when the
    // receiver re-checks the apparent start bit, followed by a full idle
    // bit so that check finishes before the next frame.
    task automatic send_frame(input int which, input logic [7:0] data, input int nbits, input logic stop_val);
        model_frame(which, data, nbits, stop_val);
        drive_bit(which, 1'b0, CPB);
        for (int i = 0; i < nbits; i++) drive_bit(which, data[i], CPB);
        if (stop_val) begin
            drive_bit(which, 1'b1, CPB);
        end else begin
            drive_bit(which, 1'b0, 48);
            drive_bit(which, 1'b1, CPB);
        end
    endtask

    task automatic check_frames(input int which, input string tag);
        logic [8:0] gq[$];
        logic [8:0] eq[$];
        logic [8:0] g, e, live, last;
        int hi, rise;
        if (which == 0) begin
            gq = got8; eq = exp8; hi = hi8; rise = rise8;
            got8.delete(); exp8.delete(); hi8 = 0; rise8 = 0;
            live = {bus8.frame_err, bus8.dout}; last = last8;
        end else begin
            gq = got7; eq = exp7; hi = hi7; rise = rise7;
            got7.delete(); exp7.delete(); hi7 = 0; rise7 = 0;
            live = {bus7.frame_err, bus7.dout}; last = last7;
        end
        chk({tag, " count"}, 32'(gq.size()), 32'(eq.size()));
        chk({tag, " pulse width"}, 32'(hi), 32'(rise));
        while (gq.size() > 0 && eq.size() > 0) begin
            g = gq.pop_front();
            e = eq.pop_front();
            chk({tag, " dout"}, 32'(g[7:0]), 32'(e[7:0]));
            chk({tag, " frame_err"}, 32'(g[8]), 32'(e[8]));
        end
        chk({tag, " hold"}, 32'(live), 32'(last));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " dout8"}, 32'(bus8.dout), 32'h0);
        chk({tag, " ferr8"}, 32'(bus8.frame_err), 32'h0);
        chk({tag, " done8"}, 32'(bus8.rx_done_tick), 32'h0);
        chk({tag, " dout7"}, 32'(bus7.dout), 32'h0);
        chk({tag, " state8"}, 32'(dut8.state_r), 32'(ST_IDLE));
    endtask

    initial begin
        logic [7:0] d;
        logic       sv;
        bus8.rx = 1'b1;
        bus7.rx = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        drive_bit(0, 1'b1, 20);

        // Plain frame
        send_frame(0, 8'hA5, 8, 1'b1);
        drive_bit(0, 1'b1, 40);
        check_frames(0, "a5");

        // Short low pulse: rejected at the mid-start check
        drive_bit(0, 1'b0, 16);
        drive_bit(0, 1'b1, 100);
        check_frames(0, "glitch");
        chk("glitch idle", 32'(dut8.state_r), 32'(ST_IDLE));

        // Framing error, byte still delivered
        send_frame(0, 8'h3C, 8, 1'b0);
        drive_bit(0, 1'b1, 40);
        check_frames(0, "3c ferr");

        // Back-to-back frames without idle gap
        send_frame(0, 8'h00, 8, 1'b1);
        send_frame(0, 8'hFF, 8, 1'b1);
        drive_bit(0, 1'b1, 40);
        check_frames(0, "b2b");

        // Reset during data bit 3 of 0x55
        drive_bit(0, 1'b0, CPB);
        for (int i = 0; i < 3; i++) drive_bit(0, d_bit(8'h55, i), CPB);
        drive_bit(0, 1'b0, 32);
        bus8.rx = 1'b1;
        reset   = 1'b1;
        last8   = 9'h000;
        last7   = 9'h000;
        repeat (3) @(negedge clock);
        check_reset_outputs("midreset");
        reset = 1'b0;
        drive_bit(0, 1'b1, 50);
        check_frames(0, "abort");
        send_frame(0, 8'h81, 8, 1'b1);
        drive_bit(0, 1'b1, 40);
        check_frames(0, "81");

        // Random frames, random gaps (including none) and stop errors
        for (int k = 0; k < 12; k++) begin
            d  = 8'($urandom_range(0, 255));
            sv = ($urandom_range(0, 3) != 0);
            send_frame(0, d, 8, sv);
            drive_bit(0, 1'b1, $urandom_range(0, 3) * 10);
        end
        drive_bit(0, 1'b1, 40);
        check_frames(0, "rand8");

        // Seven data bits
        send_frame(1, 8'h5A, 7, 1'b1);
        drive_bit(1, 1'b1, 40);
        check_frames(1, "dbit7 5a");
        for (int k = 0; k < 6; k++) begin
            d  = 8'($urandom_range(0, 255));
            sv = ($urandom_range(0, 3) != 0);
            send_frame(1, d, 7, sv);
            drive_bit(1, 1'b1, $urandom_range(0, 3) * 10);
        end
        drive_bit(1, 1'b1, 40);
        check_frames(1, "rand7");
        check_frames(0, "quiet8");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic d_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, data bits per frame (5..8).
REQ-002 Parameter SB_TICK, default 16, oversampling ticks per stop bit (16 = 1 stop bit, 32 = 2).
REQ-003 clock  input  1  system clock; all flops on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 s_tick  input  1  16x-baud enable pulse, one clock wide, from baud_gen.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clock.
REQ-007 dout  output  8  received byte, LSB-aligned; unused upper bits 0 when DBIT<8.
REQ-008 rx_done_tick  output  1  one-clock pulse when dout holds a new frame.
REQ-009 frame_err  output  1  stop-bit sample of last frame was 0; valid with rx_done_tick.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; state advances only on clocks with s_tick=1, except the IDLE exit.
REQ-012 IDLE: on rx_s=0, go to START with tick counter s=0; no s_tick needed.
REQ-013 START: on s_tick with s=7 (mid start bit), go to DATA with s=0, n=0 if rx_s=0; else return to IDLE (glitch reject).
REQ-014 START, s<7: s increments per s_tick.
REQ-015 DATA: on s_tick with s=15, sample rx_s into the shift register MSB, shift right (LSB first), s=0, n increments.
REQ-016 DATA: go to STOP after the sample with n=DBIT-1.
REQ-017 STOP: on s_tick with s=SB_TICK-1, go to IDLE and update dout and frame_err in that same clock; rx_done_tick=1 for exactly that clock.
REQ-018 frame_err SHALL equal NOT rx_s sampled at STOP s=SB_TICK-1; the byte is still delivered.
REQ-019 For DBIT<8, dout SHALL be the shift register right-shifted by 8-DBIT.
REQ-020 dout and frame_err SHALL hold between frames; no overrun flag; a new frame overwrites.
REQ-021 A new start bit SHALL be accepted on the clock after STOP returns to IDLE (back-to-back frames).
REQ-022 s is 4 bits and n 3 bits, or 5 bits when SB_TICK=32; no counter wraps outside its state rules.

Reset
REQ-023 reset SHALL force state=IDLE, s=0, n=0, shift register=0, dout=0, rx_done_tick=0, frame_err=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick; after release, the first falling edge of rx_s starts a new frame.

Structure
REQ-025 A shared package/include SHALL hold the state encodings (2-bit), the DBIT/SB_TICK defaults and the oversampling constant 16.
REQ-026 The 2-flop synchronizer SHALL be a sub-module named sync_2ff; baud_gen is instantiated by the parent, not inside uart_rx.

Verification
REQ-027 Bench uses baud_gen COUNT=3 (tick every 4 clocks) to drive s_tick; rx driven at 64 clocks per bit.
REQ-028 Frame 0xA5, 1 stop bit -> single rx_done_tick, dout=0xA5, frame_err=0.
REQ-029 rx low for 16 clocks (4 ticks) then high -> FSM back to IDLE, no rx_done_tick, dout unchanged.
REQ-030 Frame 0x3C with stop bit driven 0 -> rx_done_tick, dout=0x3C, frame_err=1.
REQ-031 Back-to-back 0x00 then 0xFF, no idle gap -> two rx_done_tick pulses, dout 0x00 then 0xFF.
REQ-032 reset pulsed during DATA bit 3 of 0x55 -> no rx_done_tick, outputs 0; next frame 0x81 -> dout=0x81.
REQ-033 DBIT=7, frame 0x5A (bits 1011010) -> dout=0x5A.
